// File: rtl/serial_link_receiver.sv
// Receiver for the inter-board serial byte link: synchronizes the peer's GPIO lines,
// deserializes one MSB-first frame and holds it in a one-entry buffer for the consumer.
module serial_link_receiver #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serialClkIn,
    input  logic              serialDataIn,
    input  logic              txReadyIn,
    output logic              rxReadyOut,
    output logic [DATA_W-1:0] byteOut,
    output logic              byteValid,
    input  logic              byteAck,
    output logic [2:0]        bitCount,
    output logic              frameErr,
    output logic              overrun,
    input  logic              errClr
);
    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StRecv, StWaitEnd, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic [SYNC_STAGES-1:0] txrdy_sync_q, txrdy_sync_d;
    logic                   sclk_prev_q, txrdy_prev_q;
    // Only the first DATA_W-1 bits are stored; the last bit goes straight into byte_q.
    logic [DATA_W-2:0]      shift_q, shift_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [DATA_W-1:0]      byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_ready_q, rx_ready_d;

    logic sclk, sdat, txrdy;
    logic clk_rise, tx_rise, last_bit;
    logic set_valid, frame_err_evt, overrun_evt;

    assign sclk     = sclk_sync_q[SYNC_STAGES-1];
    assign sdat     = sdat_sync_q[SYNC_STAGES-1];
    assign txrdy    = txrdy_sync_q[SYNC_STAGES-1];
    assign clk_rise = sclk & ~sclk_prev_q;
    assign tx_rise  = txrdy & ~txrdy_prev_q;
    assign last_bit = clk_rise && (count_q == CntW'(DATA_W - 1));

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], serialClkIn};
        sdat_sync_d   = {sdat_sync_q[SYNC_STAGES-2:0], serialDataIn};
        txrdy_sync_d  = {txrdy_sync_q[SYNC_STAGES-2:0], txReadyIn};
        state_d       = state_q;
        shift_d       = shift_q;
        count_d       = count_q;
        byte_d        = byte_q;
        set_valid     = 1'b0;
        frame_err_evt = 1'b0;
        overrun_evt   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_rise) begin
                    if (valid_q) begin
                        overrun_evt = 1'b1;
                        state_d     = StDrain;
                    end else begin
                        shift_d = '0;
                        count_d = '0;
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                // A completing edge beats a coincident txReady fall.
                if (last_bit) begin
                    byte_d    = {shift_q, sdat};
                    set_valid = 1'b1;
                    count_d   = '0;
                    state_d   = StWaitEnd;
                end else if (!txrdy) begin
                    frame_err_evt = 1'b1;
                    shift_d       = '0;
                    count_d       = '0;
                    state_d       = StIdle;
                end else if (clk_rise) begin
                    shift_d = {shift_q[DATA_W-3:0], sdat};
                    count_d = count_q + 1'b1;
                end
            end
            StWaitEnd, StDrain: begin
                if (!txrdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        valid_d     = set_valid | (valid_q & ~byteAck);
        frame_err_d = frame_err_evt | (frame_err_q & ~errClr);
        overrun_d   = overrun_evt | (overrun_q & ~errClr);
        rx_ready_d  = (state_d == StIdle) & ~valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            sclk_sync_q  <= '0;
            sdat_sync_q  <= '0;
            txrdy_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            txrdy_prev_q <= 1'b0;
            shift_q      <= '0;
            count_q      <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sdat_sync_q  <= sdat_sync_d;
            txrdy_sync_q <= txrdy_sync_d;
            sclk_prev_q  <= sclk;
            txrdy_prev_q <= txrdy;
            shift_q      <= shift_d;
            count_q      <= count_d;
            byte_q       <= byte_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rx_ready_q   <= rx_ready_d;
        end
    end

    assign rxReadyOut = rx_ready_q;
    assign byteOut    = byte_q;
    assign byteValid  = valid_q;
    assign bitCount   = 3'(count_q);
    assign frameErr   = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_link_receiver.sv
// Bench for serial_link_receiver: drives framed serial bytes and checks received bytes
// against a queue of expected values, plus flag and handshake behaviour.
module tb_serial_link_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serialClkIn = 1'b0;
    logic       serialDataIn = 1'b0;
    logic       txReadyIn = 1'b0;
    logic       rxReadyOut;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       byteAck = 1'b0;
    logic [2:0] bitCount;
    logic       frameErr;
    logic       overrun;
    logic       errClr = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [7:0]  exp_q[$];
    logic        valid_prev = 1'b0;

    always #5 clk = ~clk;

    serial_link_receiver #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serialClkIn  (serialClkIn),
        .serialDataIn (serialDataIn),
        .txReadyIn    (txReadyIn),
        .rxReadyOut   (rxReadyOut),
        .byteOut      (byteOut),
        .byteValid    (byteValid),
        .byteAck      (byteAck),
        .bitCount     (bitCount),
        .frameErr     (frameErr),
        .overrun      (overrun),
        .errClr       (errClr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: drop txReady after the frame, 1: drop it with the last clock rise,
    // 2: leave txReady high.
    task automatic send_frame(input logic [7:0] data, input int nbits, input int mode,
                              input bit chk_lat);
        txReadyIn = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            serialDataIn = data[7-i];
            serialClkIn  = 1'b0;
            repeat (4) @(negedge clk);
            serialClkIn = 1'b1;
            if (mode == 1 && i == nbits - 1) txReadyIn = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (chk_lat && i == nbits - 1 && c == 1) check("lat_pre", byteValid, 0);
                if (chk_lat && i == nbits - 1 && c == 2) check("lat_post", byteValid, 1);
            end
        end
        check("bitcount", bitCount, nbits % 8);
        serialClkIn = 1'b0;
        if (mode != 2) begin
            repeat (4) @(negedge clk);
            txReadyIn = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        byteAck = 1'b1;
        @(negedge clk);
        byteAck = 1'b0;
    endtask

    task automatic pulse_clr();
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
    endtask

    // Scoreboard: every new byteValid rise must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && byteValid && !valid_prev) begin
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_byte", byteOut, exp_q.pop_front());
            end
            valid_prev = byteValid;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", rxReadyOut, 0);
        check("rst_valid", byteValid, 0);
        check("rst_byte", byteOut, 0);
        check("rst_count", bitCount, 0);
        check("rst_ferr", frameErr, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", rxReadyOut, 1);

        // Single frame with latency check
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 0, 1'b1);
        check("a5_byte", byteOut, 8'hA5);
        check("a5_ready_full", rxReadyOut, 0);
        pulse_ack();
        check("a5_ack_valid", byteValid, 0);
        check("a5_ack_ready", rxReadyOut, 1);
        check("a5_hold", byteOut, 8'hA5);

        // Back-to-back
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 8, 0, 1'b0);
        check("3c_byte", byteOut, 8'h3C);
        pulse_ack();
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 8, 0, 1'b0);
        check("ff_byte", byteOut, 8'hFF);
        pulse_ack();
        check("b2b_ferr", frameErr, 0);
        check("b2b_ovr", overrun, 0);

        // Early abort then clean frame
        send_frame(8'h81, 5, 0, 1'b0);
        check("abort_ferr", frameErr, 1);
        check("abort_valid", byteValid, 0);
        check("abort_count", bitCount, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 8, 0, 1'b0);
        check("81_byte", byteOut, 8'h81);
        check("81_ferr_sticky", frameErr, 1);
        pulse_ack();
        pulse_clr();
        check("clr_ferr", frameErr, 0);

        // Overrun
        exp_q.push_back(8'h12);
        send_frame(8'h12, 8, 0, 1'b0);
        send_frame(8'h34, 8, 0, 1'b0);
        check("ovr_flag", overrun, 1);
        check("ovr_byte", byteOut, 8'h12);
        check("ovr_valid", byteValid, 1);
        check("ovr_ready", rxReadyOut, 0);
        pulse_ack();
        check("ovr_idle_ready", rxReadyOut, 1);
        pulse_clr();
        check("clr_ovr", overrun, 0);

        // Last clock rise coincides with txReady fall
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 8, 1, 1'b0);
        check("coin_valid", byteValid, 1);
        check("coin_byte", byteOut, 8'h5A);
        check("coin_ferr", frameErr, 0);
        pulse_ack();

        // Reset mid-frame
        send_frame(8'hC3, 3, 2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_byte", byteOut, 0);
        check("mrst_valid", byteValid, 0);
        check("mrst_count", bitCount, 0);
        check("mrst_ready", rxReadyOut, 0);
        check("mrst_ferr", frameErr, 0);
        check("mrst_ovr", overrun, 0);
        txReadyIn   = 1'b0;
        serialClkIn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 8, 0, 1'b0);
        check("c3_byte", byteOut, 8'hC3);
        check("c3_ferr", frameErr, 0);
        pulse_ack();

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
